// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are held for at most MAX_BURST beats; data and handshakes are muxed, never stored.
module fifo_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk_i,
  input  logic                               arst_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [DATA_W-1:0]                  fifo_data_o,
  output logic                               fifo_valid_o,
  input  logic                               fifo_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id_o,
  output logic                               busy_o,
  output logic [$clog2(MAX_BURST)-1:0]       burst_cnt_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] next_ptr;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           xfer;
  logic           release_grant;

  // Explicit compare-and-wrap so non-power-of-two NUM_REQ never yields an out-of-range index.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    return (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] rr_winner(input logic [IDW-1:0]     ptr,
                                               input logic [NUM_REQ-1:0] valid);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] win;
    logic           found;
    idx   = ptr;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return win;
  endfunction

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    req_ready_o   = '0;
    fifo_data_o   = '0;
    fifo_valid_o  = 1'b0;
    xfer          = 1'b0;
    release_grant = 1'b0;
    next_ptr      = wrap_inc(grant_id_q);

    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d     = GRANT;
          grant_id_d  = rr_winner(rr_ptr_q, req_valid_i);
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        fifo_data_o             = req_data_i[grant_id_q];
        fifo_valid_o            = req_valid_i[grant_id_q];
        req_ready_o[grant_id_q] = fifo_ready_i;
        xfer                    = fifo_valid_o && fifo_ready_i;
        release_grant           = (xfer && (burst_cnt_q == BW'(MAX_BURST - 1)))
                                  || !req_valid_i[grant_id_q];
        // Re-arbitrate from the rotated pointer in the release cycle to avoid an idle bubble.
        if (release_grant) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (|req_valid_i) begin
            grant_id_d = rr_winner(next_ptr, req_valid_i);
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_id_o  = grant_id_q;
  assign busy_o      = (state_q == GRANT);
  assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a 4-requester instance and a 3-requester wrap instance.
module tb_fifo_rr_arbiter;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  // Instance A: NUM_REQ=4, DATA_W=8, MAX_BURST=4
  logic [3:0][7:0] a_data;
  logic [3:0]      a_valid;
  logic [3:0]      a_ready;
  logic [7:0]      a_fdata;
  logic            a_fvalid;
  logic            a_fready;
  logic [1:0]      a_grant;
  logic            a_busy;
  logic [1:0]      a_burst;

  // Instance B: NUM_REQ=3, DATA_W=8, MAX_BURST=2
  logic [2:0][7:0] b_data;
  logic [2:0]      b_valid;
  logic [2:0]      b_ready;
  logic [7:0]      b_fdata;
  logic            b_fvalid;
  logic            b_fready;
  logic [1:0]      b_grant;
  logic            b_busy;
  logic [0:0]      b_burst;

  fifo_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut_a (
    .clk_i(clk), .arst_i(arst),
    .req_data_i(a_data), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .fifo_data_o(a_fdata), .fifo_valid_o(a_fvalid), .fifo_ready_i(a_fready),
    .grant_id_o(a_grant), .busy_o(a_busy), .burst_cnt_o(a_burst)
  );

  fifo_rr_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(2)) dut_b (
    .clk_i(clk), .arst_i(arst),
    .req_data_i(b_data), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .fifo_data_o(b_fdata), .fifo_valid_o(b_fvalid), .fifo_ready_i(b_fready),
    .grant_id_o(b_grant), .busy_o(b_busy), .burst_cnt_o(b_burst)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cnt [4];
  logic [7:0] log_q [$];
  logic [7:0] exp_rot [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Producer data is {requester index, beats already accepted from it}.
  task automatic upd_data();
    for (int i = 0; i < 4; i++) a_data[i] = 8'(i * 16 + cnt[i]);
    for (int i = 0; i < 3; i++) b_data[i] = 8'(8'hA0 + i);
  endtask

  task automatic cyc();
    logic [3:0] hs;
    @(negedge clk);
    hs = a_ready & a_valid;
    if (a_fvalid && a_fready) log_q.push_back(a_fdata);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
    upd_data();
  endtask

  task automatic do_reset();
    arst     = 1'b1;
    a_valid  = '0;
    b_valid  = '0;
    a_fready = 1'b1;
    b_fready = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    log_q.delete();
    upd_data();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    exp_rot = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h04, 8'h05, 8'h06, 8'h07};

    // Reset state and reset asserted mid-transfer
    do_reset();
    #1;
    chk("rst_busy",  32'(a_busy),   0);
    chk("rst_grant", 32'(a_grant),  0);
    chk("rst_burst", 32'(a_burst),  0);
    chk("rst_fval",  32'(a_fvalid), 0);
    chk("rst_fdata", 32'(a_fdata),  0);
    chk("rst_ready", 32'(a_ready),  0);
    a_valid = 4'b0001;
    #1;
    chk("idle_lat_busy", 32'(a_busy), 0);
    cyc(); #1;
    chk("g0_busy",  32'(a_busy),   1);
    chk("g0_fval",  32'(a_fvalid), 1);
    chk("g0_ready", 32'(a_ready),  32'h1);
    arst = 1'b1;
    #1;
    chk("arst_fval",  32'(a_fvalid), 0);
    chk("arst_ready", 32'(a_ready),  0);
    chk("arst_busy",  32'(a_busy),   0);
    chk("arst_fdata", 32'(a_fdata),  0);
    cyc();
    a_valid = '0;
    arst    = 1'b0;
    #1;
    chk("post_rst_busy", 32'(a_busy), 0);
    cyc(); #1;
    chk("idle_busy", 32'(a_busy), 0);
    chk("no_beat",   32'(log_q.size()), 0);
    a_valid = 4'b0100;
    #1;
    cyc(); #1;
    chk("g2_busy",  32'(a_busy),  1);
    chk("g2_grant", 32'(a_grant), 2);
    chk("g2_burst", 32'(a_burst), 0);
    chk("g2_fdata", 32'(a_fdata), 32'h20);
    a_valid = '0;
    #1;
    chk("g2_drop_fval", 32'(a_fvalid), 0);
    cyc(); #1;
    chk("g2_idle_busy",  32'(a_busy),  0);
    chk("g2_idle_grant", 32'(a_grant), 2);

    // Forced rotation between requesters 0 and 1
    do_reset();
    a_valid = 4'b0011;
    #1;
    cyc();
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("rot_grant_%0d", k), 32'(a_grant),  32'((k / 4) % 2));
      chk($sformatf("rot_burst_%0d", k), 32'(a_burst),  32'(k % 4));
      chk($sformatf("rot_fval_%0d",  k), 32'(a_fvalid), 1);
      chk($sformatf("rot_fdata_%0d", k), 32'(a_fdata),  32'(exp_rot[k]));
      cyc();
    end
    a_valid = '0;
    chk("rot_nbeats", 32'(log_q.size()), 12);

    // Valid withdrawal: requester 1 sends 2 beats then drops; requester 3 waits
    do_reset();
    a_valid = 4'b1010;
    #1;
    cyc(); #1;
    chk("wd_grant1", 32'(a_grant), 1);
    chk("wd_b0",     32'(a_fdata), 32'h10);
    cyc(); #1;
    chk("wd_burst1", 32'(a_burst), 1);
    chk("wd_b1",     32'(a_fdata), 32'h11);
    cyc();
    a_valid = 4'b1000;
    #1;
    chk("wd_drop_fval",  32'(a_fvalid), 0);
    chk("wd_drop_burst", 32'(a_burst),  2);
    cyc();
    a_valid = 4'b1010;
    #1;
    chk("wd_grant3", 32'(a_grant), 3);
    chk("wd_burst0", 32'(a_burst), 0);
    chk("wd_fdata3", 32'(a_fdata), 32'h30);
    chk("wd_ready3", 32'(a_ready), 32'h8);
    cyc(); #1;
    chk("wd_grant3b", 32'(a_grant), 3);
    chk("wd_burst3b", 32'(a_burst), 1);
    chk("wd_fdata3b", 32'(a_fdata), 32'h31);

    // Backpressure: 5 stalled cycles mid-grant
    do_reset();
    a_valid = 4'b0001;
    #1;
    cyc(); #1;
    chk("bp_first", 32'(a_fdata), 32'h00);
    cyc();
    a_fready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_grant_%0d", k), 32'(a_grant), 0);
      chk($sformatf("bp_burst_%0d", k), 32'(a_burst), 1);
      chk($sformatf("bp_ready_%0d", k), 32'(a_ready), 0);
      chk($sformatf("bp_fdata_%0d", k), 32'(a_fdata), 32'h01);
      cyc();
    end
    a_fready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("bp_rel_burst_%0d", k), 32'(a_burst), 32'(k + 1));
      chk($sformatf("bp_rel_fdata_%0d", k), 32'(a_fdata), 32'(k + 1));
      cyc();
    end
    a_valid = '0;
    chk("bp_nbeats", 32'(log_q.size()), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_log_%0d", i), 32'(log_q[i]), 32'(i));

    // Fairness with wrap on the 3-requester instance (MAX_BURST=2)
    do_reset();
    b_valid = 3'b111;
    #1;
    cyc();
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("wrap_grant_%0d", k), 32'(b_grant),  32'((k / 2) % 3));
      chk($sformatf("wrap_burst_%0d", k), 32'(b_burst),  32'(k % 2));
      chk($sformatf("wrap_fval_%0d",  k), 32'(b_fvalid), 1);
      chk($sformatf("wrap_fdata_%0d", k), 32'(b_fdata),  32'(8'hA0 + (k / 2) % 3));
      cyc();
    end
    b_valid = '0;

    // Sole requester re-granted every 4 beats without a bubble
    do_reset();
    a_valid = 4'b0001;
    #1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("sole_grant_%0d", k), 32'(a_grant),  0);
      chk($sformatf("sole_burst_%0d", k), 32'(a_burst),  32'(k % 4));
      chk($sformatf("sole_fval_%0d",  k), 32'(a_fvalid), 1);
      chk($sformatf("sole_fdata_%0d", k), 32'(a_fdata),  32'(k));
      cyc();
    end
    a_valid = '0;
    #1;
    chk("sole_nbeats", 32'(log_q.size()), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("sole_log_%0d", i), 32'(log_q[i]), 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
